r4_sqrt_iter_ctrl: RTL and testbench
====================================

R4_SQRT_ITER_CTRL -- requirements
Module: r4_sqrt_iter_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); rst input 1 (active-high, synchronous).
REQ-002 SHALL have the following start-side ports: start_valid_i input 1 (new operation request); start_ready_o output 1 (controller can accept); iter_num_i input 5 (radix-4 iteration count, sampled at accept); init_idx_i input 4 (initial {a0,a2,a3,a4}, sampled at accept).
REQ-003 SHALL have the following datapath ports: root_idx_i input 4 (datapath root-prefix bits {a0,a2,a3,a4}, valid during the first ITER cycle); qds_idx_o output 4 ({a0,a2,a3,a4} driving the QDS constants generator); iter_en_o output 1 (datapath performs one iteration this cycle); first_iter_o output 1 (current iteration is iteration 0); pre_en_o output 1 (datapath loads operand this cycle); post_en_o output 1 (datapath performs rounding/normalisation this cycle).
REQ-004 SHALL have the following completion and control ports: iter_cnt_o output 5 (iterations completed so far); done_valid_o output 1 (result available); done_ready_i input 1 (consumer accepts result); busy_o output 1 (state not IDLE); flush_i input 1 (abort current operation).

Function
REQ-005 SHALL implement FSM states IDLE, PRE, ITER, POST, DONE, one-hot encoded.
REQ-006 SHALL drive start_ready_o = 1 only in IDLE; accept = start_valid_i & start_ready_o.
REQ-007 SHALL transition IDLE->PRE on accept, latching iter_num_i (0 treated as 1) into the target count and init_idx_i into the index register.
REQ-008 SHALL hold PRE exactly 1 cycle with pre_en_o=1, then go to ITER with the iteration counter cleared to 0.
REQ-009 SHALL, in ITER, assert iter_en_o every cycle, increment the counter by 1 per cycle, and go to POST in the cycle the counter equals target-1.
REQ-010 SHALL assert first_iter_o only in the ITER cycle with counter=0; at the end of that cycle the index register SHALL load root_idx_i, and it SHALL then stay frozen until the next accept.
REQ-011 SHALL drive qds_idx_o directly from the index register (no combinational path from root_idx_i).
REQ-012 SHALL hold POST exactly 1 cycle with post_en_o=1, then go to DONE.
REQ-013 SHALL assert done_valid_o only in DONE; on done_valid_o & done_ready_i the FSM SHALL return to IDLE; done_valid_o SHALL stay high, with iter_cnt_o stable, until accepted.
REQ-014 SHALL place the first done_valid_o cycle exactly N+3 cycles after the accept cycle, where N is the effective iteration count; there is no back-to-back accept in the cycle done is consumed (start_ready_o is high only the following cycle).
REQ-015 SHALL make flush_i dominant over every other transition: next state IDLE, counter cleared, no done_valid_o; flush_i in IDLE has no effect.
REQ-016 SHALL make iter_cnt_o equal the number of completed iterations (N once in POST/DONE), saturating at 31.
REQ-017 SHALL keep pre_en_o, iter_en_o, post_en_o and done_valid_o mutually exclusive in every cycle.

Reset
REQ-018 SHALL, while rst=1, force state IDLE, counter 0, target 1, index register 4'b0000, all enables 0, done_valid_o 0, busy_o 0, start_ready_o 1 (the cycle after rst deasserts); rst mid-operation SHALL discard the operation without producing done_valid_o.

Configuration
REQ-019 SHALL, when macro R4_SQRT_CTRL_STALL_EN is defined, add input stall_i (1 bit); stall_i=1 in ITER SHALL deassert iter_en_o and freeze the counter, the index register and the state; stall_i SHALL be ignored in other states; flush_i SHALL override stall_i.
REQ-020 SHALL, when R4_SQRT_CTRL_STALL_EN is undefined, omit the stall_i port and advance ITER unconditionally.

Verification
REQ-021 SHALL cover: reset, then accept with iter_num_i=13, init_idx_i=4'b0101 -> PRE 1 cycle, iter_en_o for 13 cycles, post_en_o 1 cycle, done_valid_o in cycle 16 after accept, iter_cnt_o=13.
REQ-022 SHALL cover: accept with init_idx_i=4'b0011 and root_idx_i=4'b1000 during first_iter_o -> qds_idx_o=0011 during first ITER cycle, 1000 thereafter; later root_idx_i changes ignored.
REQ-023 SHALL cover: iter_num_i=0 -> exactly 1 iter_en_o cycle, done_valid_o in cycle 4 after accept.
REQ-024 SHALL cover: done_ready_i held low 5 cycles in DONE -> done_valid_o held 5+ cycles, start_valid_i ignored (start_ready_o=0) until consumption.
REQ-025 SHALL cover: flush_i at ITER counter=6 -> IDLE next cycle, no done_valid_o, start_ready_o=1; likewise rst at the same point.
REQ-026 SHALL cover: with R4_SQRT_CTRL_STALL_EN, iter_num_i=4 and stall_i high 3 cycles mid-ITER -> done_valid_o in cycle 10 after accept, 4 iter_en_o pulses total.

Source files
------------

// File: rtl/r4_sqrt_iter_ctrl.sv
// Radix-4 square-root iteration controller.
// Sequences one operation through PRE -> ITER x N -> POST -> DONE and drives the
// datapath enables plus the {a0,a2,a3,a4} index for the QDS constants generator.
// The index register holds the initial guess until the end of iteration 0, then
// the datapath root prefix.
// Optional feature: define R4_SQRT_CTRL_STALL_EN to add a stall_i input that
// freezes the ITER phase.
module r4_sqrt_iter_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid_i,
  output logic       start_ready_o,
  input  logic [4:0] iter_num_i,
  input  logic [3:0] init_idx_i,
  input  logic [3:0] root_idx_i,
  output logic [3:0] qds_idx_o,
  output logic       iter_en_o,
  output logic       first_iter_o,
  output logic       pre_en_o,
  output logic       post_en_o,
  output logic [4:0] iter_cnt_o,
  output logic       done_valid_o,
  input  logic       done_ready_i,
  output logic       busy_o,
`ifdef R4_SQRT_CTRL_STALL_EN
  input  logic       stall_i,
`endif
  input  logic       flush_i
);

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StPre  = 5'b00010,
    StIter = 5'b00100,
    StPost = 5'b01000,
    StDone = 5'b10000
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] target_q, target_d;
  logic [3:0] idx_q, idx_d;
  logic       stall;

`ifdef R4_SQRT_CTRL_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // State, counter, target and index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      target_q <= 5'd1;
      idx_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic; flush outside IDLE overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    idx_d    = idx_q;
    if (flush_i && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid_i) begin
            state_d  = StPre;
            target_d = (iter_num_i == 5'd0) ? 5'd1 : iter_num_i;
            idx_d    = init_idx_i;
            cnt_d    = 5'd0;
          end
        end
        StPre: begin
          state_d = StIter;
          cnt_d   = 5'd0;
        end
        StIter: begin
          if (!stall) begin
            cnt_d = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
            // Root prefix is only valid during iteration 0; freeze it afterwards.
            if (cnt_q == 5'd0) idx_d = root_idx_i;
            if (cnt_q == target_q - 5'd1) state_d = StPost;
          end
        end
        StPost: begin
          state_d = StDone;
        end
        StDone: begin
          if (done_ready_i) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs decode purely from registered state so enables are mutually exclusive.
  always_comb begin
    start_ready_o = (state_q == StIdle);
    busy_o        = (state_q != StIdle);
    pre_en_o      = (state_q == StPre);
    iter_en_o     = (state_q == StIter) && !stall;
    first_iter_o  = (state_q == StIter) && (cnt_q == 5'd0);
    post_en_o     = (state_q == StPost);
    done_valid_o  = (state_q == StDone);
    iter_cnt_o    = cnt_q;
    qds_idx_o     = idx_q;
  end

endmodule

// File: tb/tb_r4_sqrt_iter_ctrl.sv
// Self-checking bench for r4_sqrt_iter_ctrl: directed scenarios followed by
// randomized traffic, all compared against a phase-based reference model.
module tb_r4_sqrt_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid_i;
  logic       start_ready_o;
  logic [4:0] iter_num_i;
  logic [3:0] init_idx_i;
  logic [3:0] root_idx_i;
  logic [3:0] qds_idx_o;
  logic       iter_en_o;
  logic       first_iter_o;
  logic       pre_en_o;
  logic       post_en_o;
  logic [4:0] iter_cnt_o;
  logic       done_valid_o;
  logic       done_ready_i;
  logic       busy_o;
  logic       flush_i;
  logic       stall_v;

  always #5 clk = ~clk;

  r4_sqrt_iter_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid_i(start_valid_i),
    .start_ready_o(start_ready_o),
    .iter_num_i   (iter_num_i),
    .init_idx_i   (init_idx_i),
    .root_idx_i   (root_idx_i),
    .qds_idx_o    (qds_idx_o),
    .iter_en_o    (iter_en_o),
    .first_iter_o (first_iter_o),
    .pre_en_o     (pre_en_o),
    .post_en_o    (post_en_o),
    .iter_cnt_o   (iter_cnt_o),
    .done_valid_o (done_valid_o),
    .done_ready_i (done_ready_i),
    .busy_o       (busy_o),
`ifdef R4_SQRT_CTRL_STALL_EN
    .stall_i      (stall_v),
`endif
    .flush_i      (flush_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: an operation is a timeline of phases counted from accept.
  // k=1 PRE, k=2..n+1 iterations, k=n+2 POST, k>=n+3 DONE.
  bit         m_valid = 0;
  bit         m_act = 0;
  int         m_k = 0;
  int         m_n = 1;
  logic [3:0] m_idx = 4'b0;
  int         m_idle_cnt = 0;

  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = -1;
  int pulses = 0;
  bit prev_done = 0;

  task automatic check_outputs();
    bit pre, it, post, dn;
    int cnt;
    pre  = m_act && (m_k == 1);
    it   = m_act && (m_k >= 2) && (m_k <= m_n + 1);
    post = m_act && (m_k == m_n + 2);
    dn   = m_act && (m_k >= m_n + 3);
    if (!m_act)      cnt = m_idle_cnt;
    else if (pre)    cnt = 0;
    else if (it)     cnt = m_k - 2;
    else             cnt = m_n;
    check_eq("start_ready", start_ready_o, !m_act);
    check_eq("busy", busy_o, m_act);
    check_eq("pre_en", pre_en_o, pre);
    check_eq("iter_en", iter_en_o, it && !stall_v);
    check_eq("first_iter", first_iter_o, it && (m_k == 2));
    check_eq("post_en", post_en_o, post);
    check_eq("done_valid", done_valid_o, dn);
    check_eq("iter_cnt", iter_cnt_o, cnt);
    check_eq("qds_idx", qds_idx_o, m_idx);
  endtask

  task automatic model_update();
    bit it, dn;
    it = m_act && (m_k >= 2) && (m_k <= m_n + 1);
    dn = m_act && (m_k >= m_n + 3);
    if (rst) begin
      m_valid = 1; m_act = 0; m_idle_cnt = 0; m_idx = 4'b0;
    end else if (m_act && flush_i) begin
      m_act = 0; m_idle_cnt = 0;
    end else if (!m_act) begin
      if (start_valid_i) begin
        m_act = 1; m_k = 1;
        m_n = (iter_num_i == 0) ? 1 : int'(iter_num_i);
        m_idx = init_idx_i;
      end
    end else if (it && stall_v) begin
      // iteration frozen
    end else if (dn) begin
      if (done_ready_i) begin
        m_act = 0; m_idle_cnt = m_n;
      end
    end else begin
      if (m_k == 2) m_idx = root_idx_i;
      m_k++;
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic step(input bit sv, input logic [4:0] itn, input logic [3:0] ini,
                      input logic [3:0] rti, input bit dr, input bit fl, input bit rs,
                      input bit st);
    start_valid_i = sv;
    iter_num_i    = itn;
    init_idx_i    = ini;
    root_idx_i    = rti;
    done_ready_i  = dr;
    flush_i       = fl;
    rst           = rs;
    stall_v       = st;
    @(negedge clk);
    if (m_valid && !rs) begin
      check_outputs();
      if (sv && start_ready_o) acc_cyc = cyc;
      if (done_valid_o && !prev_done && done_cyc < 0) done_cyc = cyc;
      if (iter_en_o) pulses++;
    end
    prev_done = done_valid_o;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_step();
    step(0, 5'd0, 4'd0, 4'($urandom_range(0, 15)), 0, 0, 0, 0);
  endtask

  task automatic start_op(input logic [4:0] itn, input logic [3:0] ini);
    done_cyc = -1;
    pulses = 0;
    step(1, itn, ini, 4'($urandom_range(0, 15)), 0, 0, 0, 0);
  endtask

  // Advance with done_ready low until the first done cycle, bounded.
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_cyc < 0; i++) idle_step();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && m_act; i++) step(0, 5'd0, 4'd0, 4'd0, 1, 0, 0, 0);
    check_eq("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    step(0, 5'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    step(0, 5'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    // Reset state
    check_eq("rst_ready", start_ready_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_cnt", iter_cnt_o, 5'd0);
    check_eq("rst_idx", qds_idx_o, 4'd0);
    idle_step();

    // 13 iterations: done 16 cycles after accept
    start_op(5'd13, 4'b0101);
    wait_done(40);
    check_eq("lat13", done_cyc - acc_cyc, 16);
    check_eq("pulses13", pulses, 13);
    check_eq("cnt13", iter_cnt_o, 5'd13);
    drain();

    // Index register: initial during iteration 0, root prefix afterwards
    start_op(5'd5, 4'b0011);
    idle_step();
    check_eq("first_iter_qds", qds_idx_o, 4'b0011);
    step(0, 5'd0, 4'd0, 4'b1000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle_step();
    check_eq("qds_frozen", qds_idx_o, 4'b1000);
    drain();

    // iter_num 0 acts as 1
    start_op(5'd0, 4'b1111);
    wait_done(20);
    check_eq("lat0", done_cyc - acc_cyc, 4);
    check_eq("pulses0", pulses, 1);
    drain();

    // Hold done with back-pressure; starts refused until consumed
    start_op(5'd3, 4'b0001);
    wait_done(20);
    for (int i = 0; i < 5; i++) step(1, 5'd2, 4'd2, 4'd0, 0, 0, 0, 0);
    check_eq("done_held", done_valid_o, 1'b1);
    check_eq("held_cnt", iter_cnt_o, 5'd3);
    step(1, 5'd2, 4'd2, 4'd0, 1, 0, 0, 0);
    check_eq("ready_after_consume", start_ready_o, 1'b1);
    step(1, 5'd2, 4'd2, 4'd0, 0, 0, 0, 0);
    drain();

    // Flush at counter 6, then reset at counter 6
    for (int r = 0; r < 2; r++) begin
      start_op(5'd13, 4'b0110);
      for (int i = 0; i < 7; i++) idle_step();
      check_eq("cnt_at_abort", iter_cnt_o, 5'd6);
      step(0, 5'd0, 4'd0, 4'd0, 0, (r == 0), (r == 1), 0);
      check_eq("abort_ready", start_ready_o, 1'b1);
      check_eq("abort_done", done_valid_o, 1'b0);
      check_eq("abort_cnt", iter_cnt_o, 5'd0);
      for (int i = 0; i < 20; i++) idle_step();
    end

`ifdef R4_SQRT_CTRL_STALL_EN
    // Stall three cycles in the middle of ITER
    start_op(5'd4, 4'b1010);
    for (int i = 0; i < 3; i++) idle_step();
    for (int i = 0; i < 3; i++) step(0, 5'd0, 4'd0, 4'd0, 0, 0, 0, 1);
    wait_done(20);
    check_eq("lat_stall", done_cyc - acc_cyc, 10);
    check_eq("pulses_stall", pulses, 4);
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit st;
`ifdef R4_SQRT_CTRL_STALL_EN
      st = ($urandom_range(0, 3) == 0);
`else
      st = 0;
`endif
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom_range(0, 1), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 149) == 0), st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
